async_fifo_rd_drain: RTL and testbench

- Read-side consumer for the team's async FIFO. Runs in the FIFO read clock domain.
- Drives the FIFO's rd_en and rd_en/empty handshake. Absorbs the FIFO's one-cycle registered read latency.
- Presents the data as a valid/ready stream to downstream logic.
- Provides a flush mechanism that discards buffered and queued words, plus a delivered-word counter.

---
 rtl/async_fifo_rd_drain_if.sv | 27 ++
 rtl/async_fifo_rd_drain.sv | 123 ++++++++++++
 tb/tb_async_fifo_rd_drain.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/async_fifo_rd_drain_if.sv
// rtl/async_fifo_rd_drain_if.sv - FIFO read port, output stream and flush/status bundle
// master is the drain block; slave is the FIFO/downstream side.
interface async_fifo_rd_drain_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  flush_req;
  logic                  flush_done;
  logic                  busy;
  logic [CNT_WIDTH-1:0]  word_cnt;

  modport master (
    input  fifo_empty, fifo_data, m_ready, flush_req,
    output fifo_rd_en, m_data, m_valid, flush_done, busy, word_cnt
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready, flush_req,
    input  fifo_rd_en, m_data, m_valid, flush_done, busy, word_cnt
  );
endinterface

// File: rtl/async_fifo_rd_drain.sv
// rtl/async_fifo_rd_drain.sv - async FIFO read-side drain with skid buffer, flush and word counter
// Reads ahead only while buffered plus in-flight words fit, so m_ready never reaches fifo_rd_en.
module async_fifo_rd_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst_n,
  async_fifo_rd_drain_if.master  bus
);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);
  localparam logic [OCC_W:0]   DEPTH_C  = (OCC_W + 1)'(BUF_DEPTH);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [OCC_W-1:0]      r_occ, w_occ_nxt;
  logic [PTR_W-1:0]      r_head, w_head_nxt;
  logic [PTR_W-1:0]      r_tail, w_tail_nxt;
  logic                  r_inflight;
  logic                  r_rd_arm;
  logic                  r_flush_done, w_flush_done_nxt;
  logic [CNT_WIDTH-1:0]  r_word_cnt;
  logic [DATA_WIDTH-1:0] r_buf [BUF_DEPTH];

  logic                  w_rd_en;
  logic                  w_rd_accept;
  logic                  w_push;
  logic                  w_pop;
  logic [OCC_W:0]        w_level;

  function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign w_level     = {1'b0, r_occ} + {{OCC_W{1'b0}}, r_inflight};
  assign w_rd_accept = w_rd_en && !bus.fifo_empty;

  always_comb begin
    w_state_nxt      = r_state;
    w_occ_nxt        = r_occ;
    w_head_nxt       = r_head;
    w_tail_nxt       = r_tail;
    w_rd_en          = 1'b0;
    w_push           = 1'b0;
    w_pop            = 1'b0;
    w_flush_done_nxt = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_rd_en = r_rd_arm && !bus.fifo_empty && (w_level < DEPTH_C);
        w_pop   = (r_occ != '0) && bus.m_ready;
        if (bus.flush_req) begin
          // A handshake in this cycle still counts; the returning word is dropped.
          w_state_nxt = ST_FLUSH;
          w_occ_nxt   = '0;
          w_head_nxt  = '0;
          w_tail_nxt  = '0;
        end else begin
          w_push = r_inflight;
          if (w_push) w_tail_nxt = f_ptr_inc(r_tail);
          if (w_pop)  w_head_nxt = f_ptr_inc(r_head);
          case ({w_push, w_pop})
            2'b10:   w_occ_nxt = r_occ + 1'b1;
            2'b01:   w_occ_nxt = r_occ - 1'b1;
            default: w_occ_nxt = r_occ;
          endcase
        end
      end
      ST_FLUSH: begin
        w_rd_en = r_rd_arm && !bus.fifo_empty;
        if (bus.fifo_empty && !r_inflight) begin
          w_state_nxt      = ST_RUN;
          w_flush_done_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // r_rd_arm holds off the first read until one edge after reset release.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_state      <= ST_RUN;
      r_occ        <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_inflight   <= 1'b0;
      r_rd_arm     <= 1'b0;
      r_flush_done <= 1'b0;
      r_word_cnt   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_occ        <= w_occ_nxt;
      r_head       <= w_head_nxt;
      r_tail       <= w_tail_nxt;
      r_inflight   <= w_rd_accept;
      r_rd_arm     <= 1'b1;
      r_flush_done <= w_flush_done_nxt;
      if (w_pop) r_word_cnt <= r_word_cnt + 1'b1;
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) r_buf[i] <= '0;
    end else if (w_push) begin
      r_buf[r_tail] <= bus.fifo_data;
    end
  end

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.m_valid    = (r_occ != '0);
  assign bus.m_data     = r_buf[r_head];
  assign bus.flush_done = r_flush_done;
  assign bus.word_cnt   = r_word_cnt;
  assign bus.busy       = (r_state == ST_FLUSH) || (r_occ != '0) || r_inflight;
endmodule

// File: tb/tb_async_fifo_rd_drain.sv
// tb/tb_async_fifo_rd_drain.sv - scoreboard bench for async_fifo_rd_drain
// FIFO model returns data one cycle after an accepted read; monitor pops expected words on handshakes.
module tb_async_fifo_rd_drain;
  logic clk;
  logic rst_n;

  async_fifo_rd_drain_if #(.DATA_WIDTH(8), .CNT_WIDTH(4)) ifc();

  async_fifo_rd_drain #(
    .DATA_WIDTH(8),
    .BUF_DEPTH (3),
    .CNT_WIDTH (4)
  ) dut (
    .rd_clk  (clk),
    .rd_rst_n(rst_n),
    .bus     (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [7:0] fifo_q [$];
  logic [7:0] pend_q [$];
  logic [7:0] exp_q  [$];
  logic       fifo_clr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // FIFO model: registered read data, new words become visible one edge after being queued.
  always @(posedge clk) begin
    if (fifo_clr) begin
      fifo_q.delete();
    end else begin
      if (ifc.fifo_rd_en && !ifc.fifo_empty && fifo_q.size() > 0)
        ifc.fifo_data <= fifo_q.pop_front();
      while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
    end
    ifc.fifo_empty <= (fifo_q.size() == 0);
  end

  always @(negedge clk) begin
    if (rst_n && ifc.m_valid && ifc.m_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_extra: got 0x%0h expected no word", ifc.m_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (ifc.m_data !== e) begin
          failures++;
          $display("FAIL sb_data: got 0x%0h expected 0x%0h", ifc.m_data, e);
        end
      end
    end
    if (ifc.flush_done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] first, input int n, input int n_exp);
    for (int i = 0; i < n; i++) begin
      pend_q.push_back(first + 8'(i));
      if (i < n_exp) exp_q.push_back(first + 8'(i));
    end
  endtask

  task automatic wait_valid(input string name, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (ifc.m_valid) return;
      tick();
    end
    check(name, 32'(ifc.m_valid), 32'd1);
  endtask

  task automatic wait_drain(input string name, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (exp_q.size() == 0) return;
      tick();
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    ifc.m_ready   = 1'b1;
    ifc.flush_req = 1'b0;
    load(8'h11, 8, 8);
    // Reset held with a non-empty FIFO.
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_rd_en", 32'(ifc.fifo_rd_en), 32'd0);
      check("rst_valid", 32'(ifc.m_valid), 32'd0);
    end
    check("rst_cnt", 32'(ifc.word_cnt), 32'd0);
    check("rst_busy", 32'(ifc.busy), 32'd0);
    check("rst_fifo_empty", 32'(ifc.fifo_empty), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_rd_en0", 32'(ifc.fifo_rd_en), 32'd0);
    tick();
    check("rel_rd_en1", 32'(ifc.fifo_rd_en), 32'd1);
    tick();
    check("lat_valid_c1", 32'(ifc.m_valid), 32'd0);
    tick();
    check("lat_valid_c2", 32'(ifc.m_valid), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check("stream_valid", 32'(ifc.m_valid), 32'd1);
      tick();
    end
    check("stream_done_valid", 32'(ifc.m_valid), 32'd0);
    check("stream_cnt", 32'(ifc.word_cnt), 32'd8);
    check("stream_left", 32'(exp_q.size()), 32'd0);

    // Backpressure: head word holds, reads stop once the buffer is committed.
    ifc.m_ready = 1'b0;
    load(8'h21, 8, 8);
    wait_valid("bp_wait", 12);
    for (int i = 0; i < 5; i++) begin
      check("bp_data", 32'(ifc.m_data), 32'h21);
      check("bp_valid", 32'(ifc.m_valid), 32'd1);
      tick();
    end
    check("bp_rd_en", 32'(ifc.fifo_rd_en), 32'd0);
    check("bp_fifo_nonempty", 32'(ifc.fifo_empty), 32'd0);
    check("bp_busy", 32'(ifc.busy), 32'd1);
    ifc.m_ready = 1'b1;
    wait_drain("bp_drain", 40);
    tick();
    check("bp_cnt", 32'(ifc.word_cnt), 32'd0);

    // Flush after two delivered words.
    ifc.m_ready = 1'b0;
    load(8'h41, 8, 2);
    wait_valid("fl_wait", 12);
    for (int i = 0; i < 3; i++) tick();
    ifc.m_ready = 1'b1;
    tick();
    tick();
    ifc.m_ready   = 1'b0;
    ifc.flush_req = 1'b1;
    done_cnt      = 0;
    tick();
    ifc.flush_req = 1'b0;
    check("fl_valid", 32'(ifc.m_valid), 32'd0);
    check("fl_busy", 32'(ifc.busy), 32'd1);
    for (int i = 0; i < 30; i++) tick();
    check("fl_done_cnt", 32'(done_cnt), 32'd1);
    check("fl_busy_after", 32'(ifc.busy), 32'd0);
    check("fl_cnt", 32'(ifc.word_cnt), 32'd2);
    check("fl_fifo_empty", 32'(ifc.fifo_empty), 32'd1);
    check("fl_left", 32'(exp_q.size()), 32'd0);

    // Flush in the same cycle as the 0x33 handshake, plus a flush_req ignored in FLUSH.
    load(8'h33, 6, 1);
    wait_valid("fh_wait", 12);
    for (int i = 0; i < 3; i++) tick();
    ifc.m_ready   = 1'b1;
    ifc.flush_req = 1'b1;
    done_cnt      = 0;
    tick();
    ifc.m_ready   = 1'b0;
    ifc.flush_req = 1'b0;
    check("fh_valid", 32'(ifc.m_valid), 32'd0);
    check("fh_cnt_now", 32'(ifc.word_cnt), 32'd3);
    ifc.flush_req = 1'b1;
    tick();
    ifc.flush_req = 1'b0;
    check("fh_busy", 32'(ifc.busy), 32'd1);
    for (int i = 0; i < 30; i++) tick();
    check("fh_done_cnt", 32'(done_cnt), 32'd1);
    check("fh_cnt", 32'(ifc.word_cnt), 32'd3);
    check("fh_busy_after", 32'(ifc.busy), 32'd0);
    check("fh_left", 32'(exp_q.size()), 32'd0);

    // Reset mid-transfer, then 17 words wrap a 4-bit counter to 1.
    load(8'h60, 4, 0);
    wait_valid("mr_wait", 12);
    rst_n = 1'b0;
    #1;
    check("mr_valid", 32'(ifc.m_valid), 32'd0);
    check("mr_rd_en", 32'(ifc.fifo_rd_en), 32'd0);
    check("mr_busy", 32'(ifc.busy), 32'd0);
    check("mr_cnt", 32'(ifc.word_cnt), 32'd0);
    check("mr_data", 32'(ifc.m_data), 32'd0);
    fifo_clr = 1'b1;
    pend_q.delete();
    tick();
    tick();
    fifo_clr    = 1'b0;
    rst_n       = 1'b1;
    ifc.m_ready = 1'b1;
    load(8'h70, 17, 17);
    wait_drain("wr_drain", 80);
    tick();
    check("wr_cnt", 32'(ifc.word_cnt), 32'd1);
    check("wr_valid", 32'(ifc.m_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
